// File: rtl/gf8_div_seq.sv
// Sequential GF(2^8) divider: quo = num * den^254 via square-and-multiply, then one multiply.
// Optional macro GF8_DIV_ZERO_FASTPATH_EN: den==0 short-circuits to DONE one cycle after accept.
module gf8_div_seq #(
    parameter logic [7:0] POLY = 8'h1B
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] num,
    input  logic [7:0] den,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] quo,
    output logic       div_by_zero
);

    localparam int unsigned W     = 8;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {IDLE, EXP, MUL, DONE} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       num_q, num_d;
    logic [W-1:0]       den_q, den_d;
    logic [W-1:0]       s_q, s_d;
    logic [W-1:0]       r_q, r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       quo_q, quo_d;
    logic               dbz_q, dbz_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    // Shift-and-add carry-less multiply with on-the-fly reduction by POLY.
    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] acc;
        logic [W-1:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < int'(W); i++) begin
            if (b[i]) acc = acc ^ x;
            x = x[W-1] ? ({x[W-2:0], 1'b0} ^ POLY) : {x[W-2:0], 1'b0};
        end
        return acc;
    endfunction

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        den_d       = den_q;
        s_d         = s_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    num_d   = num;
                    den_d   = den;
                    s_d     = den;
                    r_d     = W'(1);
                    cnt_d   = '0;
                    state_d = EXP;
                end
            end
            EXP: begin
`ifdef GF8_DIV_ZERO_FASTPATH_EN
                if (den_q == '0) begin
                    quo_d       = '0;
                    dbz_d       = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
`else
                begin
`endif
                    // r accumulates den^(2+4+...+128) using the freshly squared s.
                    s_d   = gf_mul(s_q, s_q);
                    r_d   = gf_mul(r_q, s_d);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(6)) state_d = MUL;
                end
            end
            MUL: begin
                quo_d       = gf_mul(r_q, num_q);
                dbz_d       = (den_q == '0);
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            num_q       <= '0;
            den_q       <= '0;
            s_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            quo_q       <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            den_q       <= den_d;
            s_q         <= s_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quo         = quo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_gf8_div_seq.sv
// Self-checking bench for gf8_div_seq against a brute-force field-inverse reference model.
module tb_gf8_div_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] num;
    logic [7:0] den;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quo;
    logic       div_by_zero;

    int checks   = 0;
    int failures = 0;

    gf8_div_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .num         (num),
        .den         (den),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quo         (quo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Full polynomial product, then long division by x^8+x^4+x^3+x+1.
    function automatic int ref_mul(input int a, input int b);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++)
            if (((b >> i) & 1) != 0) p = p ^ (a << i);
        for (int bit_i = 14; bit_i >= 8; bit_i--)
            if (((p >> bit_i) & 1) != 0) p = p ^ (32'h11B << (bit_i - 8));
        return p;
    endfunction

    // Inverse found by exhaustive search; den=0 maps to 0.
    function automatic int ref_div(input int n, input int d);
        int inv;
        inv = 0;
        for (int x = 1; x < 256; x++)
            if (ref_mul(d, x) == 1) inv = x;
        return ref_mul(n, inv);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction with out_ready held high; checks latency, result and return to idle.
    task automatic run_div(input logic [7:0] n, input logic [7:0] d, input logic [7:0] exp_q,
                           input string tag);
        int lat;
        int elat;
        elat = 8;
`ifdef GF8_DIV_ZERO_FASTPATH_EN
        if (d == 8'h00) elat = 1;
`endif
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        num       = n;
        den       = d;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        num      = 8'($urandom);
        den      = 8'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 20);
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        check({tag, "_quo"}, 32'(quo), 32'(exp_q));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(d == 8'h00));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] hold_q;
        logic [7:0] rn;
        logic [7:0] rd;
        int lat;

        rst = 1'b1; in_valid = 1'b1; num = 8'h11; den = 8'h22; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quo", 32'(quo), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;

        // Directed vectors, with independent model cross-checks of the constants.
        check("model_53", 32'(ref_div(1, 8'h53)), 32'hCA);
        check("model_c1_83", 32'(ref_div(8'hC1, 8'h83)), 32'h57);
        run_div(8'h01, 8'h53, 8'hCA, "inv53");
        run_div(8'h01, 8'h03, 8'hF6, "inv03");
        run_div(8'h01, 8'h02, 8'h8D, "inv02");
        run_div(8'hC1, 8'h83, 8'h57, "c1_83");
        run_div(8'h57, 8'h01, 8'h57, "57_01");
        run_div(8'h00, 8'h35, 8'h00, "zero_num");
        run_div(8'h5A, 8'h00, 8'h00, "zero_den");

        // Inverse sweep over every denominator.
        for (int d = 0; d < 256; d++)
            run_div(8'h01, 8'(d), 8'(ref_div(1, d)), $sformatf("sweep_%02h", d));

        // Random operand pairs.
        for (int k = 0; k < 40; k++) begin
            rn = 8'($urandom);
            rd = 8'($urandom);
            run_div(rn, rd, 8'(ref_div(int'(rn), int'(rd))), $sformatf("rand_%0d", k));
        end

        // Backpressure: result and flags held while out_ready stays low.
        @(negedge clk);
        in_valid = 1'b1; num = 8'h9E; den = 8'h47; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 20);
        check("bp_latency", 32'(lat), 32'd8);
        hold_q = 8'(ref_div(8'h9E, 8'h47));
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_quo_%0d", c), 32'(quo), 32'(hold_q));
            check($sformatf("bp_valid_%0d", c), 32'(out_valid), 32'd1);
            check($sformatf("bp_in_ready_%0d", c), 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);

        // Reset in the 4th EXP cycle aborts the operation.
        in_valid = 1'b1; num = 8'h53; den = 8'h53;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort_busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_quo", 32'(quo), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_result", 32'(out_valid), 32'd0);
        run_div(8'h02, 8'h02, 8'h01, "post_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
